bist_march_ctrl: RTL and testbench

BIST_MARCH_CTRL -- requirements
Module: bist_march_ctrl

---
 rtl/bist_march_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bist_march_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bist_march_ctrl.sv
// rtl/bist_march_ctrl.sv - March C- memory BIST controller (optional BIST_FAIL_LOG_EN failure logging)
// Write-only M0, then read/compare(+write) pairs for M1..M5; stops on the first mismatch.
module bist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int AD_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [AD_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [AD_WIDTH-1:0]   fail_addr,
  output logic [2:0]            fail_elem
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CMP, S_DONE} state_e;

  localparam logic [2:0] ELEM_LAST = 3'd5;

  state_e                state_q, state_d;
  logic [AD_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]            elem_q, elem_d;
  logic                  fail_q, fail_d;

  logic                  start_ok;
  logic                  elem_down;
  logic                  next_down;
  logic                  addr_last;
  logic [AD_WIDTH-1:0]   addr_step;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  mismatch;

  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign next_down = (elem_q == 3'd2) || (elem_q == 3'd3);
  // The wrap of the counter is the element-end condition in either direction.
  assign addr_last = elem_down ? (addr_q == '0) : (addr_q == '1);
  assign addr_step = elem_down ? (addr_q - AD_WIDTH'(1)) : (addr_q + AD_WIDTH'(1));
  // Odd elements read zeros, even elements read ones.
  assign exp_data  = elem_q[0] ? '0 : '1;
  assign mismatch  = (mem_rdata != exp_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      elem_q  <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      elem_q  <= elem_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    elem_d  = elem_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d = S_WR;
          addr_d  = '0;
          elem_d  = '0;
          fail_d  = 1'b0;
        end
      end
      S_WR: begin
        addr_d = addr_step;
        if (addr_last) begin
          state_d = S_RD;
          elem_d  = 3'd1;
        end
      end
      S_RD: state_d = S_CMP;
      S_CMP: begin
        if (mismatch) begin
          state_d = S_DONE;
          fail_d  = 1'b1;
        end else if (addr_last) begin
          if (elem_q == ELEM_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            elem_d  = elem_q + 3'd1;
            addr_d  = next_down ? '1 : '0;
          end
        end else begin
          state_d = S_RD;
          addr_d  = addr_step;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_WR: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        mem_we   = 1'b1;
      end
      S_RD: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        mem_re   = 1'b1;
      end
      S_CMP: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        if ((elem_q != ELEM_LAST) && !mismatch) begin
          mem_we    = 1'b1;
          mem_wdata = elem_q[0] ? '1 : '0;
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign fail = fail_q;

`ifdef BIST_FAIL_LOG_EN
  logic [AD_WIDTH-1:0] fail_addr_q;
  logic [2:0]          fail_elem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else if (start_ok) begin
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else if ((state_q == S_CMP) && mismatch) begin
      fail_addr_q <= addr_q;
      fail_elem_q <= elem_q;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
`else
  assign fail_addr = '0;
  assign fail_elem = '0;
`endif

endmodule

// File: tb/tb_bist_march_ctrl.sv
// tb/tb_bist_march_ctrl.sv - directed bench for bist_march_ctrl on a 4-word memory with fault injection
module tb_bist_march_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  int nvec = 0;
  int nmis = 0;

  // 0 clean, 1 bit 3 of address 2 stuck-at-0, 2 writes to address 1 land on address 3
  int            fmode;
  logic          fill;
  logic [DW-1:0] mem [4];
  logic [DW-1:0] rd_val;
  logic [AW-1:0] wr_addr;
  int            nreads = 0;
  int            nwrites = 0;
  int            noverlap = 0;
  int            nstray = 0;

  logic          last_we;
  logic [AW-1:0] last_addr;
  int            run_reads;
  int            run_writes;
  int            lat;
  int            exp_faddr;
  int            exp_felem;

  bist_march_ctrl #(.DATA_WIDTH(DW), .AD_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  always #5 clk = ~clk;

  always_comb begin
    rd_val = mem[mem_addr];
    if (fmode == 1 && mem_addr == 2'd2) rd_val[3] = 1'b0;
    wr_addr = (fmode == 2 && mem_addr == 2'd1) ? 2'd3 : mem_addr;
  end

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 4; i++) mem[i] <= 8'hA5;
    end else if (mem_we) begin
      mem[wr_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= rd_val;
    if (mem_re) nreads <= nreads + 1;
    if (mem_we) nwrites <= nwrites + 1;
    if (mem_we && mem_re) noverlap <= noverlap + 1;
    if (!busy && (mem_we || mem_re)) nstray <= nstray + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit extra, output int latency);
    int k;
    int r0;
    int w0;
    fill = 1'b1;
    @(negedge clk);
    fill = 1'b0;
    r0 = nreads;
    w0 = nwrites;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    chk("start_clears_done", {31'b0, done}, 32'd0);
    chk("start_clears_fail", {31'b0, fail}, 32'd0);
    while (!done && k < 300) begin
      last_we   = mem_we;
      last_addr = mem_addr;
      @(negedge clk);
      k++;
      start = extra && !done && (k % 7 == 3);
    end
    start      = 1'b0;
    latency    = k - 1;
    run_reads  = nreads - r0;
    run_writes = nwrites - w0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill  = 1'b0;
    fmode = 0;
    #3;
    chk("reset_outputs", {12'b0, mem_addr, mem_wdata, mem_we, mem_re, busy, done, fail, fail_addr, fail_elem}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {30'b0, busy, done}, 32'd0);

    // Clean memory: 4 writes of M0 + 2*4 cycles for each of five read elements
    fmode = 0;
    run(1'b0, lat);
    chk("clean_latency", lat, 32'd44);
    chk("clean_done_fail", {30'b0, done, fail}, 32'b10);
    chk("clean_busy", {31'b0, busy}, 32'd0);
    chk("clean_reads", run_reads, 32'd20);
    chk("clean_writes", run_writes, 32'd20);
    chk("clean_fail_log", {27'b0, fail_addr, fail_elem}, 32'd0);

    // Stuck-at: M2 read of address 2 fails in cycle 18
`ifdef BIST_FAIL_LOG_EN
    exp_faddr = 2;
    exp_felem = 2;
`else
    exp_faddr = 0;
    exp_felem = 0;
`endif
    fmode = 1;
    run(1'b1, lat);
    chk("stuck_latency", lat, 32'd18);
    chk("stuck_done_fail", {30'b0, done, fail}, 32'b11);
    chk("stuck_fail_addr", {30'b0, fail_addr}, exp_faddr);
    chk("stuck_fail_elem", {29'b0, fail_elem}, exp_felem);
    chk("stuck_cmp_addr", {30'b0, last_addr}, 32'd2);
    chk("stuck_write_suppressed", {31'b0, last_we}, 32'd0);
    chk("stuck_reads", run_reads, 32'd7);
    chk("stuck_writes", run_writes, 32'd10);

    // Restart from a failing DONE with spurious start pulses while busy
    fmode = 0;
    run(1'b1, lat);
    chk("rerun_latency", lat, 32'd44);
    chk("rerun_done_fail", {30'b0, done, fail}, 32'b10);
    chk("rerun_fail_log", {27'b0, fail_addr, fail_elem}, 32'd0);

    // Decoder fault: address 1 never written by M0, so M1 reads stale data there
`ifdef BIST_FAIL_LOG_EN
    exp_faddr = 1;
    exp_felem = 1;
`else
    exp_faddr = 0;
    exp_felem = 0;
`endif
    fmode = 2;
    run(1'b0, lat);
    chk("alias_latency", lat, 32'd8);
    chk("alias_done_fail", {30'b0, done, fail}, 32'b11);
    chk("alias_fail_addr", {30'b0, fail_addr}, exp_faddr);
    chk("alias_fail_elem", {29'b0, fail_elem}, exp_felem);
    chk("alias_cmp_addr", {30'b0, last_addr}, 32'd1);
    chk("alias_writes", run_writes, 32'd5);

    // Reset during M3 (cycles 21..28 after the start edge)
    fmode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    chk("busy_before_reset", {31'b0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midtest_reset_outputs", {12'b0, mem_addr, mem_wdata, mem_we, mem_re, busy, done, fail, fail_addr, fail_elem}, 32'd0);
    @(negedge clk);
    chk("reset_hold_strobes", {30'b0, mem_we, mem_re}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, lat);
    chk("post_reset_latency", lat, 32'd44);
    chk("post_reset_done_fail", {30'b0, done, fail}, 32'b10);
    chk("post_reset_reads", run_reads, 32'd20);

    chk("no_we_re_overlap", noverlap, 32'd0);
    chk("no_stray_strobes", nstray, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
